// File: rtl/a5_wb_pkg.sv
// Shared constants, types and helpers for the A5 keystream Wishbone slave.
package a5_wb_pkg;

    localparam int KEY_W      = 64;
    localparam int FRAME_W    = 22;
    localparam int KS_W       = 32;
    localparam int CHAN_SHIFT = 5;
    localparam int REG_SHIFT  = 2;
    localparam int CHAN_BITS  = 3;
    localparam int REG_BITS   = 3;

    typedef logic [REG_BITS-1:0]  reg_idx_t;
    typedef logic [CHAN_BITS-1:0] chan_idx_t;

    localparam reg_idx_t REG_KS     = 3'd0;
    localparam reg_idx_t REG_STATUS = 3'd1;
    localparam reg_idx_t REG_KEY_LO = 3'd2;
    localparam reg_idx_t REG_KEY_HI = 3'd3;
    localparam reg_idx_t REG_FRAME  = 3'd4;
    localparam reg_idx_t REG_CTRL   = 3'd5;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_UFLOW_LSB = 8;
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

    typedef struct packed {
        logic      valid;
        logic      mapped;
        logic      we;
        chan_idx_t ch;
        reg_idx_t  rg;
    } wb_dec_t;

    // Byte-lane write merge: lanes with a clear select keep their old contents.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/a5_wb_if_chan_regs.sv
// One keystream channel: KEY/FRAME registers, saturating underflow counter,
// and the pop/start pulses that line up with the bus acknowledge.
module a5_wb_chan_regs
    import a5_wb_pkg::*;
#(
    parameter int UFLOW_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hit_i,
    input  logic               we_i,
    input  reg_idx_t           reg_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        dat_i,
    input  logic               ks_empty_i,
    output logic [KEY_W-1:0]   key_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic [UFLOW_W-1:0] uflow_o,
    output logic               ks_rd_en_o,
    output logic               start_o
);

    logic [KEY_W-1:0]   key_q, key_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [UFLOW_W-1:0] uflow_q, uflow_d;
    logic               pop_q, pop_d;
    logic               start_q, start_d;
    logic [31:0]        frame_merged;
    logic               unused_frame_hi;

    assign frame_merged    = merge_lanes({{(32-FRAME_W){1'b0}}, frame_q}, dat_i, sel_i);
    assign unused_frame_hi = ^frame_merged[31:FRAME_W];

    always_comb begin
        key_d   = key_q;
        frame_d = frame_q;
        uflow_d = uflow_q;
        pop_d   = 1'b0;
        start_d = 1'b0;

        if (hit_i && !we_i && reg_i == REG_KS) begin
            if (ks_empty_i) begin
                if (uflow_q != '1) begin
                    uflow_d = uflow_q + UFLOW_W'(1);
                end
            end else begin
                pop_d = 1'b1;
            end
        end

        // Evaluated after the increment so a clear always takes priority.
        if (hit_i && we_i) begin
            case (reg_i)
                REG_KEY_LO: key_d[31:0]  = merge_lanes(key_q[31:0], dat_i, sel_i);
                REG_KEY_HI: key_d[63:32] = merge_lanes(key_q[63:32], dat_i, sel_i);
                REG_FRAME:  frame_d      = frame_merged[FRAME_W-1:0];
                REG_CTRL: begin
                    if (sel_i[0]) begin
                        start_d = dat_i[CTRL_START_BIT];
                        if (dat_i[CTRL_CLR_BIT]) begin
                            uflow_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            frame_q <= '0;
            uflow_q <= '0;
            pop_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            frame_q <= frame_d;
            uflow_q <= uflow_d;
            pop_q   <= pop_d;
            start_q <= start_d;
        end
    end

    assign key_o      = key_q;
    assign frame_o    = frame_q;
    assign uflow_o    = uflow_q;
    assign ks_rd_en_o = pop_q;
    assign start_o    = start_q;

endmodule

// File: rtl/a5_wb_if.sv
// Wishbone classic slave fronting CHANNELS A5 keystream generators.
// Define A5_WB_IF_ERR_EN to answer unmapped accesses with wbs_err_o instead of wbs_ack_o.
module a5_wb_if
    import a5_wb_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int UFLOW_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_dat_i,
    input  logic [31:0]                 wbs_adr_i,
    output logic                        wbs_ack_o,
`ifdef A5_WB_IF_ERR_EN
    output logic                        wbs_err_o,
`endif
    output logic [31:0]                 wbs_dat_o,
    input  logic [KS_W*CHANNELS-1:0]    ks_data_i,
    input  logic [CHANNELS-1:0]         ks_empty_i,
    output logic [CHANNELS-1:0]         ks_rd_en_o,
    output logic [KEY_W*CHANNELS-1:0]   key_o,
    output logic [FRAME_W*CHANNELS-1:0] frame_o,
    output logic [CHANNELS-1:0]         start_o
);

    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        rdata;
    logic               busy;
    wb_dec_t            dec;
    logic [CHANNELS-1:0] ch_hit;
    logic [UFLOW_W-1:0] uflow [CHANNELS];
    logic               unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:CHAN_SHIFT+CHAN_BITS], wbs_adr_i[REG_SHIFT-1:0]};

`ifdef A5_WB_IF_ERR_EN
    logic err_q, err_d;
    assign busy = ack_q | err_q;
`else
    assign busy = ack_q;
`endif

    // A new access is only taken while no response is on the bus, which
    // forces an idle cycle between back-to-back responses.
    always_comb begin
        dec        = '0;
        dec.valid  = wbs_stb_i & wbs_cyc_i & ~busy;
        dec.we     = wbs_we_i;
        dec.ch     = wbs_adr_i[CHAN_SHIFT +: CHAN_BITS];
        dec.rg     = wbs_adr_i[REG_SHIFT +: REG_BITS];
        dec.mapped = ({29'd0, dec.ch} < 32'(CHANNELS)) && (dec.rg <= REG_CTRL);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign ch_hit[c] = dec.valid && dec.mapped && (dec.ch == 3'(c));

        a5_wb_chan_regs #(
            .UFLOW_W (UFLOW_W)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .hit_i      (ch_hit[c]),
            .we_i       (dec.we),
            .reg_i      (dec.rg),
            .sel_i      (wbs_sel_i),
            .dat_i      (wbs_dat_i),
            .ks_empty_i (ks_empty_i[c]),
            .key_o      (key_o[c*KEY_W +: KEY_W]),
            .frame_o    (frame_o[c*FRAME_W +: FRAME_W]),
            .uflow_o    (uflow[c]),
            .ks_rd_en_o (ks_rd_en_o[c]),
            .start_o    (start_o[c])
        );
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (dec.ch == 3'(c)) begin
                case (dec.rg)
                    REG_KS:     rdata = ks_empty_i[c] ? '0 : ks_data_i[c*KS_W +: KS_W];
                    REG_STATUS: begin
                        rdata[STAT_EMPTY_BIT]             = ks_empty_i[c];
                        rdata[STAT_UFLOW_LSB +: UFLOW_W]  = uflow[c];
                    end
                    REG_KEY_LO: rdata = key_o[c*KEY_W +: 32];
                    REG_KEY_HI: rdata = key_o[c*KEY_W+32 +: 32];
                    REG_FRAME:  rdata[FRAME_W-1:0] = frame_o[c*FRAME_W +: FRAME_W];
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign dat_d = (dec.valid && dec.mapped && !dec.we) ? rdata : '0;

`ifdef A5_WB_IF_ERR_EN
    assign ack_d = dec.valid & dec.mapped;
    assign err_d = dec.valid & ~dec.mapped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wbs_err_o = err_q;
`else
    assign ack_d = dec.valid;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_a5_wb_if.sv
// Self-checking bench for a5_wb_if: register-map model compared every cycle,
// plus directed transactions with literal expectations.
module tb_a5_wb_if;

    localparam int CH = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  wdat = '0;
    logic [31:0]  adr = '0;
    logic         ack;
    logic         err;
    logic [31:0]  rdat;
    logic [31:0]  ks_dat [CH];
    logic [1:0]   ks_empty = 2'b11;
    logic [1:0]   rd_en;
    logic [127:0] key;
    logic [43:0]  frame;
    logic [1:0]   start;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [63:0] m_key   [CH];
    logic [21:0] m_frame [CH];
    int          m_uf    [CH];
    logic        exp_ack = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_dat = '0;
    logic [1:0]  exp_pop = '0;
    logic [1:0]  exp_start = '0;

    always #5 clk = ~clk;

    a5_wb_if #(.CHANNELS(CH), .UFLOW_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (wdat),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
`ifdef A5_WB_IF_ERR_EN
        .wbs_err_o  (err),
`endif
        .wbs_dat_o  (rdat),
        .ks_data_i  ({ks_dat[1], ks_dat[0]}),
        .ks_empty_i (ks_empty),
        .ks_rd_en_o (rd_en),
        .key_o      (key),
        .frame_o    (frame),
        .start_o    (start)
    );

`ifndef A5_WB_IF_ERR_EN
    assign err = 1'b0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [31:0] A(input int ch, input int rg);
        return 32'(ch * 32 + rg * 4);
    endfunction

    // Register-map model: decides each cycle what the bus must answer next.
    initial begin
        for (int c = 0; c < CH; c++) begin
            m_key[c] = '0; m_frame[c] = '0; m_uf[c] = 0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int c = 0; c < CH; c++) begin
                    m_key[c] = '0; m_frame[c] = '0; m_uf[c] = 0;
                end
                exp_ack = 0; exp_err = 0; exp_dat = '0; exp_pop = '0; exp_start = '0;
            end else begin : step
                logic        acc, mapped;
                int          ch, rg;
                logic [31:0] t;
                acc    = stb && cyc && !exp_ack && !exp_err;
                ch     = int'(adr[7:5]);
                rg     = int'(adr[4:2]);
                mapped = (ch < CH) && (rg < 6);
                exp_ack = acc; exp_err = 0; exp_dat = '0; exp_pop = '0; exp_start = '0;
`ifdef A5_WB_IF_ERR_EN
                exp_ack = acc && mapped;
                exp_err = acc && !mapped;
`endif
                if (acc && mapped) begin
                    if (!we) begin
                        case (rg)
                            0: if (ks_empty[ch]) begin
                                   if (m_uf[ch] < 255) m_uf[ch]++;
                               end else begin
                                   exp_dat = ks_dat[ch];
                                   exp_pop[ch] = 1'b1;
                               end
                            1: exp_dat = 32'(m_uf[ch] * 256) | {31'd0, ks_empty[ch]};
                            2: exp_dat = m_key[ch][31:0];
                            3: exp_dat = m_key[ch][63:32];
                            4: exp_dat = {10'd0, m_frame[ch]};
                            default: exp_dat = '0;
                        endcase
                    end else begin
                        case (rg)
                            2: m_key[ch][31:0]  = lanes(m_key[ch][31:0], wdat, sel);
                            3: m_key[ch][63:32] = lanes(m_key[ch][63:32], wdat, sel);
                            4: begin
                                   t = lanes({10'd0, m_frame[ch]}, wdat, sel);
                                   m_frame[ch] = t[21:0];
                               end
                            5: if (sel[0]) begin
                                   if (wdat[0]) exp_start[ch] = 1'b1;
                                   if (wdat[1]) m_uf[ch] = 0;
                               end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial forever begin
        @(negedge clk);
        check("ack",    {127'd0, ack}, {127'd0, exp_ack});
        check("err",    {127'd0, err}, {127'd0, exp_err});
        check("dat",    {96'd0, rdat}, {96'd0, exp_dat});
        check("rd_en",  {126'd0, rd_en}, {126'd0, exp_pop});
        check("start",  {126'd0, start}, {126'd0, exp_start});
        check("key",    key, {m_key[1], m_key[0]});
        check("frame",  {84'd0, frame}, {84'd0, m_frame[1], m_frame[0]});
    end

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] r,
                        output logic [1:0] pop, output logic [1:0] st, output logic e);
        logic ok;
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = a; sel = s; wdat = d;
        ok = 0; r = '0; pop = '0; st = '0; e = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (ack || err) begin
                ok = 1; r = rdat; pop = rd_en; st = start; e = err;
            end
        end
        stb = 0; cyc = 0; we = 0;
        if (!ok) check("xfer_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [1:0]  pop, st;
        logic        e;
        int          n_ack, n_st;
        logic [3:0]  pat;

        ks_dat[0] = '0; ks_dat[1] = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        #2 reset_n = 1;

        // Reset values of channel 0 registers
        xfer(0, A(0, 2), 4'hF, 0, r, pop, st, e); check("rst_key_lo", {96'd0, r}, 128'h0);
        xfer(0, A(0, 3), 4'hF, 0, r, pop, st, e); check("rst_key_hi", {96'd0, r}, 128'h0);
        xfer(0, A(0, 4), 4'hF, 0, r, pop, st, e); check("rst_frame",  {96'd0, r}, 128'h0);
        xfer(0, A(0, 1), 4'hF, 0, r, pop, st, e); check("rst_status", {96'd0, r}, 128'h1);
        @(negedge clk); check("ack_single", {127'd0, ack}, 128'h0);

        // Partial byte-lane write, upper/low address bits ignored
        xfer(1, 32'hABCD_0000 | A(1, 2) | 32'h3, 4'b0101, 32'h1234_5678, r, pop, st, e);
        xfer(0, A(1, 2), 4'hF, 0, r, pop, st, e);
        check("key_lo_sel", {96'd0, r}, 128'h0034_0078);
        check("key_o1_lo", {96'd0, key[95:64]}, 128'h0034_0078);
        xfer(1, A(1, 3), 4'hF, 32'hCAFE_BABE, r, pop, st, e);
        check("key_o1_hi", {96'd0, key[127:96]}, 128'hCAFE_BABE);
        xfer(1, A(1, 4), 4'hF, 32'hFFFF_FFFF, r, pop, st, e);
        xfer(0, A(1, 4), 4'hF, 0, r, pop, st, e);
        check("frame_trunc", {96'd0, r}, 128'h003F_FFFF);
        check("frame_o1", {106'd0, frame[43:22]}, 128'h3F_FFFF);
        xfer(0, A(1, 5), 4'hF, 0, r, pop, st, e); check("ctrl_reads0", {96'd0, r}, 128'h0);

        // Keystream pop
        ks_dat[0] = 32'hDEAD_BEEF; ks_empty[0] = 0;
        xfer(0, A(0, 0), 4'hF, 0, r, pop, st, e);
        check("ks_data", {96'd0, r}, 128'hDEAD_BEEF);
        check("ks_pop", {126'd0, pop}, 128'h1);
        @(negedge clk); check("pop_one_cycle", {126'd0, rd_en}, 128'h0);

        // Underflow counting, non-clearing CTRL, saturation and clear
        ks_empty[0] = 1;
        for (int i = 0; i < 3; i++) xfer(0, A(0, 0), 4'hF, 0, r, pop, st, e);
        xfer(1, A(0, 5), 4'b1110, 32'h3, r, pop, st, e);
        xfer(0, A(0, 1), 4'hF, 0, r, pop, st, e);
        check("status_uf3", {96'd0, r}, 128'h0000_0301);
        check("no_start_sel", {126'd0, st}, 128'h0);
        for (int i = 0; i < 297; i++) begin
            xfer(0, A(0, 0), 4'hF, 0, r, pop, st, e);
            check("ks_empty_dat", {96'd0, r}, 128'h0);
            check("ks_empty_pop", {126'd0, pop}, 128'h0);
        end
        xfer(0, A(0, 1), 4'hF, 0, r, pop, st, e);
        check("status_sat", {96'd0, r}, 128'h0000_FF01);
        xfer(1, A(0, 5), 4'h1, 32'h2, r, pop, st, e);
        xfer(0, A(0, 1), 4'hF, 0, r, pop, st, e);
        check("status_clr", {96'd0, r}, 128'h0000_0001);

        // Single CTRL start on channel 0
        xfer(1, A(0, 5), 4'h1, 32'h1, r, pop, st, e);
        check("start_ch0", {126'd0, st}, 128'h1);

        // Held strobe: responses separated by an idle cycle
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = A(1, 5); sel = 4'h1; wdat = 32'h1;
        n_ack = 0; n_st = 0; pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
            if (start[1]) n_st++;
            pat[i] = ack;
        end
        stb = 0; cyc = 0; we = 0;
        @(negedge clk);
        if (ack) n_ack++;
        if (start[1]) n_st++;
        check("held_acks", 128'(n_ack), 128'd2);
        check("held_starts", 128'(n_st), 128'd2);
        check("held_pattern", {124'd0, pat}, 128'h5);

        // Unmapped channel / register, ignored writes
        ks_empty = 2'b00;
        xfer(0, A(3, 0), 4'hF, 0, r, pop, st, e);
        check("unmapped_dat", {96'd0, r}, 128'h0);
        check("unmapped_pop", {126'd0, pop}, 128'h0);
`ifdef A5_WB_IF_ERR_EN
        check("unmapped_err", {127'd0, e}, 128'h1);
`else
        check("unmapped_err", {127'd0, e}, 128'h0);
`endif
        xfer(1, A(0, 6), 4'hF, 32'hFFFF_FFFF, r, pop, st, e);
        xfer(0, A(0, 6), 4'hF, 0, r, pop, st, e);
        check("reg6_read", {96'd0, r}, 128'h0);
        xfer(1, A(0, 0), 4'hF, 32'h1234_0000, r, pop, st, e);
        check("ks_write_pop", {126'd0, pop}, 128'h0);
        ks_empty = 2'b11;

        // Reset asserted during a pending access
        xfer(1, A(0, 2), 4'hF, 32'h5555_AAAA, r, pop, st, e);
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = A(0, 2); sel = 4'hF;
        #2 reset_n = 0;
        @(negedge clk);
        stb = 0; cyc = 0;
        #2 reset_n = 1;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("rst_discard_ack", 128'(n_ack), 128'd0);
        check("rst_key_clear", key, 128'h0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
